// File: rtl/div_unit_pkg.sv
// Shared widths, state codes and handshake levels for the divide unit.
// Every module of the divider takes these names from here rather than repeating literals.
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [DoubleRegBus-1:0] ZeroDoubleWord = '0;
  localparam logic [RegBus-1:0]       ZeroWord       = '0;

endpackage

// File: rtl/div_unit_abs.sv
// Conditional two's-complement negate: y = neg ? -a : a.
// Gives operand magnitudes on entry and restores result signs on exit.
module div_abs
  import div_unit_pkg::*;
(
  input  logic              neg,
  input  logic [RegBus-1:0] a,
  output logic [RegBus-1:0] y
);

  assign y = neg ? (~a + {{(RegBus-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/div_unit.sv
// 32-bit restoring divider, one quotient bit per clock, MSB first.
// result_o = {remainder, quotient}; signed mode divides magnitudes and fixes the signs at the end.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_t        state_reg;
  logic [4:0]        cnt_reg;
  logic [RegBus-1:0] rem_reg;
  logic [RegBus-1:0] quo_reg;
  logic [RegBus-1:0] divisor_reg;
  logic              quo_sign_reg;
  logic              rem_sign_reg;

  // Operand magnitudes: index 0 is the dividend, index 1 the divisor.
  logic [RegBus-1:0] op_raw [2];
  logic [RegBus-1:0] op_mag [2];

  assign op_raw[0] = opdata1_i;
  assign op_raw[1] = opdata2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op_abs
      div_abs u_op_abs (
        .neg (signed_div_i & op_raw[gi][RegBus-1]),
        .a   (op_raw[gi]),
        .y   (op_mag[gi])
      );
    end
  endgenerate

  // The one shared subtractor: shifted partial remainder minus divisor.
  // Bit 32 set means the trial went negative and the old remainder is kept.
  logic [RegBus:0]   trial;
  logic [RegBus-1:0] rem_step;
  logic [RegBus-1:0] quo_step;

  assign trial = {rem_reg, quo_reg[RegBus-1]} - {1'b0, divisor_reg};

  always_comb begin
    rem_step = {rem_reg[RegBus-2:0], quo_reg[RegBus-1]};
    quo_step = {quo_reg[RegBus-2:0], 1'b0};
    if (!trial[RegBus]) begin
      rem_step = trial[RegBus-1:0];
      quo_step = {quo_reg[RegBus-2:0], 1'b1};
    end
  end

  logic [RegBus-1:0] quo_fixed;
  logic [RegBus-1:0] rem_fixed;

  div_abs u_quo_fix (
    .neg (quo_sign_reg),
    .a   (quo_step),
    .y   (quo_fixed)
  );

  div_abs u_rem_fix (
    .neg (rem_sign_reg),
    .a   (rem_step),
    .y   (rem_fixed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= DivFree;
      cnt_reg      <= '0;
      rem_reg      <= ZeroWord;
      quo_reg      <= ZeroWord;
      divisor_reg  <= ZeroWord;
      quo_sign_reg <= 1'b0;
      rem_sign_reg <= 1'b0;
      result_o     <= ZeroDoubleWord;
      ready_o      <= DivResultNotReady;
    end else begin
      case (state_reg)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            rem_reg      <= ZeroWord;
            quo_reg      <= op_mag[0];
            divisor_reg  <= op_mag[1];
            quo_sign_reg <= signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
            rem_sign_reg <= signed_div_i & opdata1_i[RegBus-1];
            cnt_reg      <= '0;
            state_reg    <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
          end
        end

        DivByZero: begin
          if (annul_i) begin
            state_reg <= DivFree;
          end else begin
            state_reg <= DivEnd;
            result_o  <= ZeroDoubleWord;
            ready_o   <= DivResultReady;
          end
        end

        DivOn: begin
          if (annul_i) begin
            state_reg <= DivFree;
            result_o  <= ZeroDoubleWord;
            ready_o   <= DivResultNotReady;
          end else begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg == 5'd31) begin
              state_reg <= DivEnd;
              result_o  <= {rem_fixed, quo_fixed};
              ready_o   <= DivResultReady;
            end
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            state_reg <= DivFree;
            result_o  <= ZeroDoubleWord;
            ready_o   <= DivResultNotReady;
          end
        end

        default: state_reg <= DivFree;
      endcase
    end
  end

endmodule
